// File: rtl/input_port_buffer_if.sv
// Handshake bundle between one router input port and its flit buffer:
// upstream flit push, arbiter request/grant, and crossbar-side head flit.
interface input_port_buffer_if #(
   parameter int NR    = 5,
   parameter int DW    = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic [DW-1:0] in_flit;
   logic          in_ready;
   logic [NR-1:0] req;
   logic          grt;
   logic          out_valid;
   logic [DW-1:0] out_flit;
   logic [CW-1:0] count;
   logic          err;

   modport master (
      output in_valid, in_flit, grt,
      input  in_ready, req, out_valid, out_flit, count, err
   );

   modport slave (
      input  in_valid, in_flit, grt,
      output in_ready, req, out_valid, out_flit, count, err
   );
endinterface

// File: rtl/input_port_buffer.sv
// Per-input-port wormhole flit FIFO with XY routing of the head flit and a
// held one-hot output request from HEAD to TAIL.
module input_port_buffer #(
   parameter int NR    = 5,
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int X_W   = 2,
   parameter int Y_W   = 2,
   parameter int CUR_X = 0,
   parameter int CUR_Y = 0
) (
   input logic                 clk,
   input logic                 rst,
   input_port_buffer_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [NR-1:0] route_q, route_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          err;
   logic [NR-1:0] req;
   logic [NR-1:0] route;
   logic [DW-1:0] head;
   logic [1:0]    head_type;
   logic [X_W-1:0] dx;
   logic [Y_W-1:0] dy;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign head      = mem_q[rd_ptr_q[AW-1:0]];
   assign head_type = head[DW-1:DW-2];
   assign dx        = head[X_W-1:0];
   assign dy        = head[X_W+Y_W-1:X_W];

   assign bus.in_ready  = !full && !rst;
   assign push          = bus.in_valid && !full && !rst;
   assign bus.req       = req;
   assign bus.out_valid = |req;
   assign bus.out_flit  = head;
   assign bus.count     = wr_ptr_q - rd_ptr_q;
   assign bus.err       = err;

   // Dimension-ordered routing: resolve X first, then Y, else eject locally.
   always_comb begin
      route = '0;
      if (dx > X_W'(CUR_X)) begin
         route[1] = 1'b1;
      end else if (dx < X_W'(CUR_X)) begin
         route[2] = 1'b1;
      end else if (dy > Y_W'(CUR_Y)) begin
         route[3] = 1'b1;
      end else if (dy < Y_W'(CUR_Y)) begin
         route[4] = 1'b1;
      end else begin
         route[0] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      route_d = route_q;
      req     = '0;
      pop     = 1'b0;
      err     = 1'b0;
      if (!rst && !empty) begin
         case (state_q)
            IDLE: begin
               if (head_type == T_HEAD || head_type == T_SINGLE) begin
                  req = route;
                  if (bus.grt) begin
                     pop = 1'b1;
                     if (head_type == T_HEAD) begin
                        state_d = ACTIVE;
                        route_d = route;
                     end
                  end
               end else begin
                  pop = 1'b1;
                  err = 1'b1;
               end
            end
            ACTIVE: begin
               // Any flit type is payload here; the packet ends on TAIL/SINGLE.
               req = route_q;
               if (bus.grt) begin
                  pop = 1'b1;
                  if (head_type == T_TAIL || head_type == T_SINGLE) begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = bus.in_flit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         route_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         route_q  <= route_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (1,1): routing, FIFO limits,
// wormhole hold across gaps, orphan discard and mid-packet reset.
module tb_input_port_buffer;

   localparam int NR    = 5;
   localparam int DEPTH = 4;
   localparam int DW    = 32;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   logic clk = 1'b0;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   input_port_buffer_if #(.NR(NR), .DW(DW), .DEPTH(DEPTH)) bus ();

   input_port_buffer #(
      .NR(NR), .DEPTH(DEPTH), .DW(DW), .X_W(2), .Y_W(2), .CUR_X(1), .CUR_Y(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   function automatic logic [DW-1:0] mk(logic [1:0] t, logic [1:0] dx, logic [1:0] dy,
                                        logic [7:0] tag);
      return {t, 18'h0, tag, dy, dx};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_flit  = '0;
      bus.grt      = 1'b0;
      tick();
      tick();
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL rst_req: got %b want 00000", bus.req); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", bus.count); end
      vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", bus.err); end
      rst = 1'b0;
      #1;
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_single();
      logic [DW-1:0] f;
      f = mk(T_SINGLE, 2'd3, 2'd1, 8'h11);
      bus.in_valid = 1'b1;
      bus.in_flit  = f;
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00010) begin miscompares++; $display("FAIL single_req: got %b want 00010", bus.req); end
      vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", bus.count); end
      vectors++; if (bus.out_flit !== f) begin miscompares++; $display("FAIL single_flit: got %h want %h", bus.out_flit, f); end
      bus.grt = 1'b1;
      tick();
      bus.grt = 1'b0;
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d want 0", bus.count); end
      vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL single_pop_req: got %b want 00000", bus.req); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_flit  = mk(T_SINGLE, 2'd1, 2'd1, 8'(i));
         tick();
      end
      vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", bus.count); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", bus.in_ready); end
      bus.in_flit = mk(T_SINGLE, 2'd1, 2'd1, 8'h55);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL full_fifth_count: got %0d want 4", bus.count); end
      vectors++; if (bus.req !== 5'b00001) begin miscompares++; $display("FAIL full_req: got %b want 00001", bus.req); end
      vectors++; if (bus.out_flit !== mk(T_SINGLE, 2'd1, 2'd1, 8'h00)) begin miscompares++; $display("FAIL full_head0: got %h want %h", bus.out_flit, mk(T_SINGLE, 2'd1, 2'd1, 8'h00)); end
      bus.grt = 1'b1;
      tick();
      bus.grt = 1'b0;
      vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL full_pop_count: got %0d want 3", bus.count); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_ready: got %b want 1", bus.in_ready); end
      vectors++; if (bus.out_flit !== mk(T_SINGLE, 2'd1, 2'd1, 8'h01)) begin miscompares++; $display("FAIL full_head1: got %h want %h", bus.out_flit, mk(T_SINGLE, 2'd1, 2'd1, 8'h01)); end
      bus.grt = 1'b1;
      tick();
      tick();
      tick();
      bus.grt = 1'b0;
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL full_drain_count: got %0d want 0", bus.count); end
   endtask

   task automatic test_packet();
      logic [DW-1:0] pkt [4];
      pkt[0] = mk(T_HEAD, 2'd1, 2'd0, 8'hA0);
      pkt[1] = mk(T_BODY, 2'd0, 2'd0, 8'hA1);
      pkt[2] = mk(T_BODY, 2'd3, 2'd3, 8'hA2);
      pkt[3] = mk(T_TAIL, 2'd0, 2'd0, 8'hA3);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_flit  = pkt[i];
         tick();
      end
      bus.in_valid = 1'b0;
      bus.grt      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (bus.req !== 5'b10000) begin miscompares++; $display("FAIL pkt_req%0d: got %b want 10000", i, bus.req); end
         vectors++; if (bus.out_flit !== pkt[i]) begin miscompares++; $display("FAIL pkt_flit%0d: got %h want %h", i, bus.out_flit, pkt[i]); end
         tick();
      end
      vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL pkt_end_req: got %b want 00000", bus.req); end
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL pkt_end_count: got %0d want 0", bus.count); end
      bus.grt      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_HEAD, 2'd1, 2'd1, 8'hB0);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00001) begin miscompares++; $display("FAIL pkt_local_req: got %b want 00001", bus.req); end
      bus.grt = 1'b1;
      tick();
      bus.grt      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_TAIL, 2'd3, 2'd0, 8'hB1);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00001) begin miscompares++; $display("FAIL pkt_local_tail_req: got %b want 00001", bus.req); end
      bus.grt = 1'b1;
      tick();
      bus.grt = 1'b0;
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL pkt_local_count: got %0d want 0", bus.count); end
   endtask

   task automatic test_stall();
      logic [DW-1:0] body;
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_HEAD, 2'd0, 2'd1, 8'hC0);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00100) begin miscompares++; $display("FAIL stall_head_req: got %b want 00100", bus.req); end
      bus.grt = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL stall_gap_req%0d: got %b want 00000", i, bus.req); end
         vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL stall_gap_count%0d: got %0d want 0", i, bus.count); end
         tick();
      end
      bus.grt      = 1'b0;
      body         = mk(T_BODY, 2'd3, 2'd3, 8'hC1);
      bus.in_valid = 1'b1;
      bus.in_flit  = body;
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00100) begin miscompares++; $display("FAIL stall_body_req: got %b want 00100", bus.req); end
      vectors++; if (bus.out_flit !== body) begin miscompares++; $display("FAIL stall_body_flit: got %h want %h", bus.out_flit, body); end
      bus.grt = 1'b1;
      tick();
      bus.grt      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_TAIL, 2'd3, 2'd3, 8'hC2);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00100) begin miscompares++; $display("FAIL stall_tail_req: got %b want 00100", bus.req); end
      bus.grt = 1'b1;
      tick();
      bus.grt = 1'b0;
      vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL stall_tail_done_req: got %b want 00000", bus.req); end
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_SINGLE, 2'd3, 2'd1, 8'hC3);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.req !== 5'b00010) begin miscompares++; $display("FAIL stall_idle_reroute: got %b want 00010", bus.req); end
      bus.grt = 1'b1;
      tick();
      bus.grt = 1'b0;
   endtask

   task automatic test_orphan();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_BODY, 2'd1, 2'd1, 8'hD0);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL orphan_err: got %b want 1", bus.err); end
      vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL orphan_req: got %b want 00000", bus.req); end
      vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL orphan_count: got %0d want 1", bus.count); end
      tick();
      vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL orphan_err_clear: got %b want 0", bus.err); end
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL orphan_discard_count: got %0d want 0", bus.count); end
   endtask

   task automatic test_back_to_back();
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_HEAD, 2'd1, 2'd0, 8'hE0);
      tick();
      for (int i = 1; i < 4; i++) begin
         bus.in_flit = mk(T_BODY, 2'd0, 2'd0, 8'(8'hE0 + i));
         tick();
      end
      bus.in_flit = mk(T_BODY, 2'd0, 2'd0, 8'hE9);
      bus.grt     = 1'b1;
      #1;
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready: got %b want 0", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      bus.grt      = 1'b0;
      vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL b2b_count: got %0d want 3", bus.count); end
      vectors++; if (bus.req !== 5'b10000) begin miscompares++; $display("FAIL b2b_active_req: got %b want 10000", bus.req); end
      vectors++; if (bus.out_flit !== mk(T_BODY, 2'd0, 2'd0, 8'hE1)) begin miscompares++; $display("FAIL b2b_head: got %h want %h", bus.out_flit, mk(T_BODY, 2'd0, 2'd0, 8'hE1)); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL b2b_rst_count: got %0d want 0", bus.count); end
      vectors++; if (bus.req !== 5'b00000) begin miscompares++; $display("FAIL b2b_rst_req: got %b want 00000", bus.req); end
      bus.in_valid = 1'b1;
      bus.in_flit  = mk(T_BODY, 2'd0, 2'd0, 8'hE5);
      tick();
      bus.in_valid = 1'b0;
      vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL b2b_rst_idle_err: got %b want 1", bus.err); end
      tick();
      vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL b2b_final_count: got %0d want 0", bus.count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_packet();
      test_stall();
      test_orphan();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
